// File: rtl/xif_core_initiator.sv
// Core-side CV-X-IF initiator: allocates X_IDs, issues, commits in order, retires results.
// Optional: define COMMIT_KILL_EN to add kill_req and kill committed instructions.
module xif_core_initiator #(
  parameter int X_ID_WIDTH      = 4,
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_instr,
  input  logic [XLEN-1:0]       req_rs1,
  input  logic [XLEN-1:0]       req_rs2,
  input  logic                  drain,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [31:0]           issue_instr,
  output logic [X_ID_WIDTH-1:0] issue_id,
  output logic [XLEN-1:0]       issue_rs1,
  output logic [XLEN-1:0]       issue_rs2,
  input  logic                  issue_accept,
  output logic                  commit_valid,
  output logic [X_ID_WIDTH-1:0] commit_id,
  output logic                  commit_kill,
`ifdef COMMIT_KILL_EN
  input  logic                  kill_req,
`endif
  input  logic                  result_valid,
  output logic                  result_ready,
  input  logic [X_ID_WIDTH-1:0] result_id,
  input  logic [XLEN-1:0]       result_data,
  output logic                  wb_valid,
  output logic [XLEN-1:0]       wb_data,
  output logic [X_ID_WIDTH:0]   outstanding,
  output logic                  idle,
  output logic [15:0]           err_cnt
);
  localparam int NUM_IDS = 1 << X_ID_WIDTH;
  localparam logic [X_ID_WIDTH:0] MAX_CNT = (X_ID_WIDTH+1)'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_STALL, S_DRAIN} state_e;
  state_e state_q, state_d;

  logic                  issue_valid_q, issue_valid_d;
  logic [31:0]           issue_instr_q, issue_instr_d;
  logic [X_ID_WIDTH-1:0] issue_id_q, issue_id_d;
  logic [XLEN-1:0]       issue_rs1_q, issue_rs1_d;
  logic [XLEN-1:0]       issue_rs2_q, issue_rs2_d;
  logic                  commit_valid_q, commit_valid_d;
  logic [X_ID_WIDTH-1:0] commit_id_q, commit_id_d;
  logic                  commit_kill_q, commit_kill_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic [X_ID_WIDTH:0]   outstanding_q, outstanding_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [X_ID_WIDTH-1:0] next_id_q, next_id_d;
  logic [NUM_IDS-1:0]    sb_q, sb_d;

  logic issue_hs, issue_acc, res_hs, res_ok, res_err, kill_clr;
  logic pending_stuck, blocked, req_hs, req_ready_c;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    issue_hs  = issue_valid_q & issue_ready;
    issue_acc = issue_hs & issue_accept;
    res_hs    = result_valid & ~rst & (outstanding_q != '0);
    res_ok    = res_hs & sb_q[result_id];
    res_err   = result_valid & ~res_ok;
    kill_clr  = 1'b0;
`ifdef COMMIT_KILL_EN
    // A result for the same ID in the same cycle already retires it.
    kill_clr  = commit_valid_q & commit_kill_q & sb_q[commit_id_q] &
                ~(res_ok & (result_id == commit_id_q));
`endif

    sb_d = sb_q;
    if (res_ok)    sb_d[result_id]   = 1'b0;
    if (kill_clr)  sb_d[commit_id_q] = 1'b0;
    if (issue_acc) sb_d[issue_id_q]  = 1'b1;

    next_id_d     = issue_acc ? next_id_q + 1'b1 : next_id_q;
    outstanding_d = outstanding_q + (X_ID_WIDTH+1)'(issue_acc)
                  - (X_ID_WIDTH+1)'(res_ok) - (X_ID_WIDTH+1)'(kill_clr);

    // Never hand out an ID that is still in flight after this cycle's updates.
    blocked       = (outstanding_d >= MAX_CNT) | sb_d[next_id_d];
    pending_stuck = issue_valid_q & ~issue_ready;
    req_ready_c   = ~rst & ((state_q == S_IDLE) | (state_q == S_ISSUE)) &
                    ~pending_stuck & ~blocked & ~drain;
    req_hs        = req_valid & req_ready_c;

    issue_valid_d = issue_valid_q;
    issue_instr_d = issue_instr_q;
    issue_id_d    = issue_id_q;
    issue_rs1_d   = issue_rs1_q;
    issue_rs2_d   = issue_rs2_q;
    if (issue_hs) issue_valid_d = 1'b0;
    if (req_hs) begin
      issue_valid_d = 1'b1;
      issue_instr_d = req_instr;
      issue_id_d    = next_id_d;
      issue_rs1_d   = req_rs1;
      issue_rs2_d   = req_rs2;
    end

    commit_valid_d = issue_acc;
    commit_id_d    = issue_acc ? issue_id_q : commit_id_q;
    commit_kill_d  = 1'b0;
`ifdef COMMIT_KILL_EN
    commit_kill_d  = issue_acc & kill_req;
`endif

    wb_valid_d = res_ok;
    wb_data_d  = res_ok ? result_data : wb_data_q;
    err_cnt_d  = res_err ? sat_inc16(err_cnt_q) : err_cnt_q;

    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (drain)          state_d = S_DRAIN;
        else if (req_valid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (pending_stuck)   state_d = S_WAIT;
        else if (drain)      state_d = S_DRAIN;
        else if (req_hs)     state_d = S_ISSUE;
        else if (!req_valid) state_d = S_IDLE;
        else if (blocked)    state_d = S_STALL;
      end
      S_WAIT: begin
        if (issue_ready) state_d = drain ? S_DRAIN : S_ISSUE;
      end
      S_STALL: begin
        if (drain)                 state_d = S_DRAIN;
        else if (res_ok | kill_clr) state_d = S_ISSUE;
      end
      S_DRAIN: begin
        if ((outstanding_q == '0) && !drain) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      issue_valid_q  <= 1'b0;
      issue_instr_q  <= '0;
      issue_id_q     <= '0;
      issue_rs1_q    <= '0;
      issue_rs2_q    <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      commit_kill_q  <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      outstanding_q  <= '0;
      err_cnt_q      <= '0;
      next_id_q      <= '0;
      sb_q           <= '0;
    end else begin
      issue_valid_q  <= issue_valid_d;
      issue_instr_q  <= issue_instr_d;
      issue_id_q     <= issue_id_d;
      issue_rs1_q    <= issue_rs1_d;
      issue_rs2_q    <= issue_rs2_d;
      commit_valid_q <= commit_valid_d;
      commit_id_q    <= commit_id_d;
      commit_kill_q  <= commit_kill_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      outstanding_q  <= outstanding_d;
      err_cnt_q      <= err_cnt_d;
      next_id_q      <= next_id_d;
      sb_q           <= sb_d;
    end
  end

  assign req_ready    = req_ready_c;
  assign issue_valid  = issue_valid_q;
  assign issue_instr  = issue_instr_q;
  assign issue_id     = issue_id_q;
  assign issue_rs1    = issue_rs1_q;
  assign issue_rs2    = issue_rs2_q;
  assign commit_valid = commit_valid_q;
  assign commit_id    = commit_id_q;
  assign commit_kill  = commit_kill_q;
  assign result_ready = ~rst & (outstanding_q != '0);
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign outstanding  = outstanding_q;
  assign idle         = ~rst & (state_q == S_IDLE) & (outstanding_q == '0);
  assign err_cnt      = err_cnt_q;
endmodule

// File: tb/tb_xif_core_initiator.sv
// Bench for xif_core_initiator: directed scenarios plus randomized traffic against a
// transaction-level model of ID allocation, in-flight set, commits, writebacks and errors.
module tb_xif_core_initiator;
  localparam int W = 4, XLEN = 32, MAXO = 8, NID = 16;

  logic ck = 1'b0, rst = 1'b1;
  logic req_valid = 0, req_ready, drain = 0;
  logic [31:0] req_instr = '0;
  logic [XLEN-1:0] req_rs1 = '0, req_rs2 = '0;
  logic issue_valid, issue_ready = 0, issue_accept = 0;
  logic [31:0] issue_instr;
  logic [W-1:0] issue_id, commit_id, result_id = '0;
  logic [XLEN-1:0] issue_rs1, issue_rs2, result_data = '0, wb_data;
  logic commit_valid, commit_kill, result_valid = 0, result_ready, wb_valid, idle;
  logic [W:0] outstanding;
  logic [15:0] err_cnt;

  always #5 ck = ~ck;

  xif_core_initiator #(.X_ID_WIDTH(W), .XLEN(XLEN), .MAX_OUTSTANDING(MAXO)) dut (
    .ck(ck), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .drain(drain), .issue_valid(issue_valid),
    .issue_ready(issue_ready), .issue_instr(issue_instr), .issue_id(issue_id),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_accept(issue_accept),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_data(result_data), .wb_valid(wb_valid), .wb_data(wb_data),
    .outstanding(outstanding), .idle(idle), .err_cnt(err_cnt));

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference state
  bit m_infl[NID];
  int m_cnt, m_next, m_err, n_acc, n_rq;
  bit m_pv, e_cv, e_wv;
  int e_cid;
  logic [31:0] m_pi, e_wd;
  logic [XLEN-1:0] m_p1, m_p2;
  int cpq[$];

  // Stimulus for the next cycle
  bit s_req_valid, s_drain, s_ir, s_acc, s_rv;
  logic [31:0] s_instr, s_rdata;
  logic [XLEN-1:0] s_rs1, s_rs2;
  logic [W-1:0] s_rid;

  task automatic model_clear();
    for (int i = 0; i < NID; i++) m_infl[i] = 0;
    m_cnt = 0; m_next = 0; m_err = 0; m_pv = 0; e_cv = 0; e_wv = 0;
    cpq.delete();
  endtask

  task automatic quiet_stim();
    s_req_valid = 0; s_drain = 0; s_ir = 1; s_acc = 1; s_rv = 0;
    s_instr = $urandom; s_rs1 = $urandom; s_rs2 = $urandom; s_rdata = $urandom; s_rid = '0;
  endtask

  task automatic pick_result(input bit en);
    s_rv = 0;
    s_rdata = $urandom;
    if (en && cpq.size() > 0) begin
      s_rv = 1;
      s_rid = W'(cpq[$urandom_range(0, cpq.size() - 1)]);
    end
  endtask

  task automatic cycle();
    bit pv_pre, rq, ih, rule_ok;
    int cnt_pre;
    req_valid = s_req_valid; req_instr = s_instr; req_rs1 = s_rs1; req_rs2 = s_rs2;
    drain = s_drain; issue_ready = s_ir; issue_accept = s_acc;
    result_valid = s_rv; result_id = s_rid; result_data = s_rdata;
    #1;
    pv_pre = m_pv; cnt_pre = m_cnt;
    check("result_ready", 64'(result_ready), 64'(cnt_pre > 0));
    rq = req_valid && req_ready;
    ih = pv_pre && issue_ready;
    e_cv = 0; e_wv = 0;
    if (result_valid) begin
      if (cnt_pre > 0 && m_infl[result_id]) begin
        m_infl[result_id] = 0; m_cnt--; e_wv = 1; e_wd = result_data;
      end else if (m_err < 65535) m_err++;
      if (cnt_pre > 0)
        foreach (cpq[i]) if (cpq[i] == int'(result_id)) begin cpq.delete(i); break; end
    end
    if (ih) begin
      if (issue_accept) begin
        e_cv = 1; e_cid = m_next; m_infl[m_next] = 1; m_cnt++; n_acc++;
        cpq.push_back(m_next);
        m_next = (m_next + 1) % NID;
      end
      m_pv = 0;
    end
    if (rq) begin
      m_pv = 1; m_pi = req_instr; m_p1 = req_rs1; m_p2 = req_rs2; n_rq++;
    end
    rule_ok = !drain && !(pv_pre && !issue_ready) && (m_cnt < MAXO) && !m_infl[m_next];
    check("req_ready_rule", 64'(req_ready && !rule_ok), 64'(0));
    @(negedge ck);
    check("issue_valid", 64'(issue_valid), 64'(m_pv));
    if (m_pv) begin
      check("issue_id", 64'(issue_id), 64'(m_next));
      check("issue_instr", 64'(issue_instr), 64'(m_pi));
      check("issue_rs", {issue_rs1, issue_rs2}, {m_p1, m_p2});
    end
    check("commit_valid", 64'(commit_valid), 64'(e_cv));
    if (e_cv) check("commit_id", 64'(commit_id), 64'(e_cid));
    check("commit_kill", 64'(commit_kill), 64'(0));
    check("wb_valid", 64'(wb_valid), 64'(e_wv));
    if (e_wv) check("wb_data", 64'(wb_data), 64'(e_wd));
    check("outstanding", 64'(outstanding), 64'(m_cnt));
    check("err_cnt", 64'(err_cnt), 64'(m_err));
  endtask

  task automatic do_reset();
    rst = 1;
    req_valid = 0; drain = 0; issue_ready = 0; issue_accept = 0; result_valid = 0;
    model_clear();
    #1;
    check("rst_ctrl", 64'({req_ready, issue_valid, commit_valid, commit_kill, result_ready,
                           wb_valid, idle}), 64'(0));
    check("rst_instr", 64'(issue_instr), 64'(0));
    check("rst_ops", {issue_rs1, issue_rs2}, 64'(0));
    check("rst_wb", 64'(wb_data), 64'(0));
    check("rst_cnt", 64'({outstanding, err_cnt, issue_id, commit_id}), 64'(0));
    @(negedge ck);
    rst = 0;
    #1;
    check("idle_after_rst", 64'(idle), 64'(1));
    quiet_stim();
  endtask

  initial begin
    bit rej_done;
    logic [31:0] held;
    model_clear();
    quiet_stim();
    @(negedge ck);
    do_reset();

    // Single FADD.S
    s_req_valid = 1; s_instr = 32'h0020_F0D3; cycle();
    check("fadd_issue_id", 64'({issue_valid, issue_id}), 64'({1'b1, 4'd0}));
    s_req_valid = 0; cycle();
    check("fadd_commit", 64'({commit_valid, commit_id}), 64'({1'b1, 4'd0}));
    check("fadd_out1", 64'(outstanding), 64'(1));
    s_rv = 1; s_rid = 0; s_rdata = 32'h4040_0000; cycle();
    check("fadd_wb", 64'({wb_valid, wb_data}), 64'({1'b1, 32'h4040_0000}));
    check("fadd_out0", 64'(outstanding), 64'(0));
    quiet_stim(); cycle();

    // issue_ready held low for 3 cycles
    s_req_valid = 1; s_ir = 0; held = 32'hABCD_1234; s_instr = held; cycle();
    s_req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_instr", 64'(issue_instr), 64'(held));
      check("hold_no_commit", 64'(commit_valid), 64'(0));
    end
    s_ir = 1; cycle(); cycle();
    pick_result(1); cycle(); quiet_stim(); cycle();

    // Fill to MAX_OUTSTANDING, then free IDs to continue past the wrap
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      s_req_valid = 1; s_instr = $urandom; s_rs1 = $urandom; s_rs2 = $urandom; cycle();
    end
    check("stall_at_max", 64'(outstanding), 64'(MAXO));
    check("stall_no_issue", 64'(issue_valid), 64'(0));
    for (int i = 0; i < 40; i++) begin
      s_req_valid = 1; s_instr = $urandom; pick_result(1); cycle();
    end
    check("wrap_reached", 64'(n_acc >= 17), 64'(1));
    quiet_stim();
    for (int i = 0; i < 30 && m_cnt > 0; i++) begin pick_result(1); cycle(); end

    // Reject ID 5: no commit, ID reused
    do_reset();
    rej_done = 0;
    for (int i = 0; i < 14; i++) begin
      s_req_valid = 1; s_instr = $urandom; pick_result(1);
      s_acc = !(issue_valid && issue_id == 5 && !rej_done);
      cycle();
      if (!s_acc && !rej_done) begin
        rej_done = 1;
        check("reuse_id5", 64'({issue_valid, issue_id}), 64'({1'b1, 4'd5}));
      end
    end
    check("reject_seen", 64'(rej_done), 64'(1));
    quiet_stim();
    for (int i = 0; i < 30 && (m_cnt > 0 || m_pv); i++) begin pick_result(1); cycle(); end

    // Result for an ID never issued
    do_reset();
    s_req_valid = 1; cycle(); s_req_valid = 0; cycle();
    s_rv = 1; s_rid = 9; cycle();
    check("bogus_err", 64'(err_cnt), 64'(1));
    check("bogus_no_wb", 64'(wb_valid), 64'(0));

    // Drain with 3 outstanding
    do_reset();
    n_rq = 0;
    for (int i = 0; i < 10 && n_rq < 3; i++) begin s_req_valid = 1; cycle(); end
    s_req_valid = 0;
    for (int i = 0; i < 10 && m_pv; i++) cycle();
    check("drain_out3", 64'(outstanding), 64'(3));
    s_drain = 1; s_req_valid = 1; cycle();
    check("drain_req_ready", 64'(req_ready), 64'(0));
    for (int i = 0; i < 3; i++) begin pick_result(1); cycle(); end
    quiet_stim();
    for (int i = 0; i < 20 && !idle; i++) cycle();
    check("drain_idle", 64'(idle), 64'(1));

    // Reset mid-flight, then a late result
    for (int i = 0; i < 5; i++) begin s_req_valid = 1; s_instr = $urandom; cycle(); end
    @(negedge ck);
    do_reset();
    s_rv = 1; s_rid = 0; cycle();
    check("late_result_err", 64'(err_cnt), 64'(1));
    quiet_stim(); cycle();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s_req_valid = ($urandom_range(0, 3) != 0);
      s_instr = $urandom; s_rs1 = $urandom; s_rs2 = $urandom;
      s_drain = ($urandom_range(0, 99) < 3);
      s_ir = ($urandom_range(0, 3) != 0);
      s_acc = ($urandom_range(0, 7) != 0);
      pick_result($urandom_range(0, 2) != 0);
      if (!s_rv && $urandom_range(0, 24) == 0) begin s_rv = 1; s_rid = W'($urandom); end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
